// File: rtl/ula_exec_stage_if.sv
// Handshake, ULA operand/result and writeback signals of ula_exec_stage.
// The stage itself connects through the master modport; its environment uses slave.
interface ula_exec_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] instr;
  logic [2:0]  ula_a;
  logic [2:0]  ula_b;
  logic [4:0]  ula_op;
  logic [2:0]  ula_resu;
  logic        ula_o;
  logic        ula_c;
  logic        ula_s;
  logic        ula_z;
  logic        out_valid;
  logic [2:0]  out_resu;
  logic [3:0]  flags;
  logic        err;

  modport master (
    input  in_valid, instr, ula_resu, ula_o, ula_c, ula_s, ula_z,
    output in_ready, ula_a, ula_b, ula_op, out_valid, out_resu, flags, err
  );

  modport slave (
    output in_valid, instr, ula_resu, ula_o, ula_c, ula_s, ula_z,
    input  in_ready, ula_a, ula_b, ula_op, out_valid, out_resu, flags, err
  );
endinterface

// File: rtl/ula_exec_stage.sv
// Execute/writeback controller around the 3-bit ULA: one instruction every 3 cycles.
// Optional macro ULA_DEBUG_EN adds a side-effect-free register-file read port.
module ula_exec_stage #(
  parameter int NREGS = 8
) (
  input logic              clk,
  input logic              rst,
  ula_exec_stage_if.master bus
`ifdef ULA_DEBUG_EN
  ,
  input  logic [2:0]       dbg_addr,
  output logic [2:0]       dbg_data
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic [2:0]  regs [NREGS];
  logic [13:0] instr_q;
  logic [4:0]  op_q;
  logic [2:0]  rd_q;
  logic [2:0]  rb_q;
  logic        is_alu;
  logic        is_ldi;
  logic [2:0]  wb_value;
  logic [3:0]  flags_next;

  // R0 is never written, but the read still forces zero so it is hardwired.
  function automatic logic [2:0] read_reg(input logic [2:0] addr);
    return (addr == 3'd0) ? 3'd0 : regs[addr];
  endfunction

  assign op_q = instr_q[13:9];
  assign rd_q = instr_q[8:6];
  assign rb_q = instr_q[2:0];

  always_comb begin
    state_next   = state;
    bus.in_ready = 1'b0;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (bus.in_valid) state_next = EXEC;
      end
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    is_alu = (op_q == 5'b01000) || (op_q == 5'b01001) || op_q[4];
    is_ldi = (op_q == 5'b00001);
    if (is_alu)      wb_value = bus.ula_resu;
    else if (is_ldi) wb_value = rb_q;
    else             wb_value = 3'd0;
  end

  // Flag register is {O,C,S,Z}; each bit has its own set of opcodes that refresh it.
  always_comb begin
    flags_next = bus.flags;
    if (is_alu) begin
      flags_next[3] = bus.ula_o;
      if ((op_q == 5'b01000) || (op_q == 5'b01001))
        flags_next[2] = bus.ula_c;
      if ((op_q != 5'b10011) && (op_q != 5'b11111) && (op_q != 5'b10000))
        flags_next[1] = bus.ula_s;
      if ((op_q != 5'b10011) && (op_q != 5'b11111))
        flags_next[0] = bus.ula_z;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      instr_q       <= '0;
      bus.ula_a     <= '0;
      bus.ula_b     <= '0;
      bus.ula_op    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_resu  <= '0;
      bus.flags     <= '0;
      bus.err       <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state         <= state_next;
      bus.out_valid <= 1'b0;
      bus.err       <= 1'b0;
      if (accept) begin
        instr_q    <= bus.instr;
        bus.ula_op <= bus.instr[13:9];
        bus.ula_a  <= read_reg(bus.instr[5:3]);
        bus.ula_b  <= read_reg(bus.instr[2:0]);
      end
      if (state == WB) begin
        bus.out_valid <= 1'b1;
        bus.out_resu  <= wb_value;
        bus.err       <= !(is_alu || is_ldi);
        bus.flags     <= flags_next;
        if ((is_alu || is_ldi) && (rd_q != 3'd0))
          regs[rd_q] <= wb_value;
      end
    end
  end

`ifdef ULA_DEBUG_EN
  assign dbg_data = read_reg(dbg_addr);
`endif

endmodule

// File: tb/tb_ula_exec_stage.sv
// Self-checking bench for ula_exec_stage: directed scenarios plus random instructions
// checked against a register-file/flag model; covers ULA_DEBUG_EN when defined.
module tb_ula_exec_stage;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [2:0] model_regs [8];
  logic mo, mc, ms, mz;

  always #5 clk = ~clk;

  ula_exec_stage_if bus ();

`ifdef ULA_DEBUG_EN
  logic [2:0] dbg_addr;
  logic [2:0] dbg_data;
`endif

  ula_exec_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ULA_DEBUG_EN
    ,
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
`endif
  );

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = 3'd0;
    {mo, mc, ms, mz} = 4'b0000;
  endtask

  // Issues one instruction, plays the ULA with the given response and checks the whole pass.
  task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] resu, input logic [3:0] uf,
                       input bit hold);
    logic [2:0] exp_resu;
    logic       alu, ldi;
    int         waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL ready_wait: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.instr    = {op, rd, ra, rb};
    @(posedge clk); #1;
    if (!hold) bus.in_valid = 1'b0;
    bus.instr = 14'($urandom);
    checks += 4;
    if (bus.ula_a !== model_regs[ra]) begin
      errors++; $display("[TB] FAIL ula_a: got %0d required %0d (ra=%0d)", bus.ula_a, model_regs[ra], ra);
    end
    if (bus.ula_b !== model_regs[rb]) begin
      errors++; $display("[TB] FAIL ula_b: got %0d required %0d (rb=%0d)", bus.ula_b, model_regs[rb], rb);
    end
    if (bus.ula_op !== op) begin
      errors++; $display("[TB] FAIL ula_op: got %b required %b", bus.ula_op, op);
    end
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL busy_ready: in_ready=%b required 0", bus.in_ready);
    end
    bus.ula_resu = resu;
    {bus.ula_o, bus.ula_c, bus.ula_s, bus.ula_z} = uf;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL early_valid: out_valid=%b required 0", bus.out_valid);
    end
    alu = (op == 5'b01000) || (op == 5'b01001) || (op >= 5'b10000);
    ldi = (op == 5'b00001);
    exp_resu = alu ? resu : (ldi ? rb : 3'd0);
    if ((alu || ldi) && rd != 3'd0) model_regs[rd] = exp_resu;
    if (alu) begin
      mo = uf[3];
      if (op == 5'b01000 || op == 5'b01001) mc = uf[2];
      if (op != 5'b10011 && op != 5'b11111 && op != 5'b10000) ms = uf[1];
      if (op != 5'b10011 && op != 5'b11111) mz = uf[0];
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks += 5;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL out_valid: got %b required 1 (op=%b)", bus.out_valid, op);
    end
    if (bus.out_resu !== exp_resu) begin
      errors++; $display("[TB] FAIL out_resu: got %0d required %0d (op=%b)", bus.out_resu, exp_resu, op);
    end
    if (bus.err !== !(alu || ldi)) begin
      errors++; $display("[TB] FAIL err: got %b required %b (op=%b)", bus.err, !(alu || ldi), op);
    end
    if (bus.flags !== {mo, mc, ms, mz}) begin
      errors++; $display("[TB] FAIL flags: got %b required %b (op=%b)", bus.flags, {mo, mc, ms, mz}, op);
    end
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL ready_after_wb: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks += 8;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: got %b required 1", bus.in_ready); end
    if (bus.ula_a !== 3'd0) begin errors++; $display("[TB] FAIL rst_ula_a: got %0d required 0", bus.ula_a); end
    if (bus.ula_b !== 3'd0) begin errors++; $display("[TB] FAIL rst_ula_b: got %0d required 0", bus.ula_b); end
    if (bus.ula_op !== 5'd0) begin errors++; $display("[TB] FAIL rst_ula_op: got %b required 0", bus.ula_op); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b required 0", bus.out_valid); end
    if (bus.out_resu !== 3'd0) begin errors++; $display("[TB] FAIL rst_resu: got %0d required 0", bus.out_resu); end
    if (bus.flags !== 4'd0) begin errors++; $display("[TB] FAIL rst_flags: got %b required 0000", bus.flags); end
    if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b required 0", bus.err); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL idle_cycle%0d: valid=%b ready=%b required 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
`ifdef ULA_DEBUG_EN
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++;
      if (dbg_data !== 3'd0) begin errors++; $display("[TB] FAIL rst_dbg_r%0d: got %0d required 0", i, dbg_data); end
    end
`endif
  endtask

  task automatic test_directed();
    issue(5'b00001, 3'd1, 3'd0, 3'd5, 3'($urandom), 4'($urandom), 1'b0);
    issue(5'b10001, 3'd2, 3'd1, 3'd1, 3'd5, 4'b0010, 1'b0);
    issue(5'b00001, 3'd1, 3'd0, 3'd6, 3'($urandom), 4'($urandom), 1'b0);
    issue(5'b01000, 3'd3, 3'd1, 3'd1, 3'd4, 4'b0110, 1'b0);
    issue(5'b10100, 3'd6, 3'd2, 3'd3, 3'd0, 4'b0001, 1'b0);
    issue(5'b11111, 3'd4, 3'd1, 3'd1, 3'd1, 4'b0010, 1'b0);
    issue(5'b10000, 3'd4, 3'd4, 3'd4, 3'd0, 4'b0011, 1'b0);
    issue(5'b00110, 3'd3, 3'd3, 3'd4, 3'd7, 4'b1111, 1'b0);
    issue(5'b00001, 3'd0, 3'd0, 3'd7, 3'd2, 4'b1111, 1'b0);
    issue(5'b10000, 3'd1, 3'd0, 3'd3, 3'd6, 4'b1000, 1'b0);
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1;
    bus.instr    = {5'b00001, 3'd5, 3'd0, 3'd3};
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks += 2;
    if (bus.ula_op !== 5'd0 || bus.flags !== 4'd0) begin
      errors++; $display("[TB] FAIL mid_rst_state: ula_op=%b flags=%b required 0", bus.ula_op, bus.flags);
    end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_ready: got %b required 1", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL mid_rst_drop%0d: valid=%b err=%b ready=%b required 0/0/1", i, bus.out_valid, bus.err, bus.in_ready);
      end
    end
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr = {5'b10010, 3'd1, 3'd2, 3'd3};
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.ula_op !== 5'd0) begin
      errors++; $display("[TB] FAIL rst_over_accept: ready=%b ula_op=%b required 1/00000", bus.in_ready, bus.ula_op);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_over_retire: valid=%b required 0", bus.out_valid); end
    issue(5'b10000, 3'd0, 3'd5, 3'd5, 3'd1, 4'b0000, 1'b0);
  endtask

  task automatic test_back_to_back();
    issue(5'b00001, 3'd7, 3'd0, 3'd2, 3'd0, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL single_accept%0d: valid=%b ready=%b required 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
    issue(5'b01001, 3'd6, 3'd7, 3'd7, 3'd3, 4'b1100, 1'b0);
    issue(5'b11000, 3'd5, 3'd6, 3'd7, 3'd5, 4'b0011, 1'b0);
  endtask

  task automatic test_random();
    logic [4:0] op;
    int         pick;
    for (int n = 0; n < 60; n++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 2)       op = 5'b00001;
      else if (pick == 2) op = {4'b0100, 1'($urandom)};
      else if (pick == 3) op = 5'($urandom);
      else                op = {1'b1, 4'($urandom)};
      issue(op, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 4'($urandom), 1'($urandom));
    end
`ifdef ULA_DEBUG_EN
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      checks++;
      if (dbg_data !== model_regs[i]) begin
        errors++; $display("[TB] FAIL dbg_r%0d: got %0d required %0d", i, dbg_data, model_regs[i]);
      end
    end
`endif
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.instr    = '0;
    bus.ula_resu = '0;
    {bus.ula_o, bus.ula_c, bus.ula_s, bus.ula_z} = 4'b0000;
`ifdef ULA_DEBUG_EN
    dbg_addr = '0;
`endif
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
